// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: multi-cycle issue controller for the 32-bit lab ALU.
//
// Accepts one instruction plus its rs/rt operands over a valid/ready handshake.
// It decodes the instruction into ALU operands and the 5-bit ALUfn code
// {subtract, bool1, bool0, shft, math}. It drives the ALU for one cycle, then
// captures R/FlagZ and returns the result, branch decision and illegal flag
// over a second valid/ready handshake.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake
//   instr                 MIPS-format instruction word
//   rs_val, rt_val        register operands
//   alu_A, alu_B, alu_fn  registered drive to the ALU
//   alu_R, alu_Z          combinational ALU result and zero flag
//   out_valid/out_ready   output handshake
//   out_result            captured R (0 for illegal instructions)
//   out_taken             branch taken (beq/bne only)
//   out_illegal           unsupported instruction
module alu_issue_ctrl #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  instr,
  input  logic [N-1:0] rs_val,
  input  logic [N-1:0] rt_val,
  output logic [N-1:0] alu_A,
  output logic [N-1:0] alu_B,
  output logic [4:0]   alu_fn,
  input  logic [N-1:0] alu_R,
  input  logic         alu_Z,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic         out_taken,
  output logic         out_illegal
);

  localparam logic [4:0] FnAdd  = 5'b00001;
  localparam logic [4:0] FnSub  = 5'b10001;
  localparam logic [4:0] FnAnd  = 5'b00000;
  localparam logic [4:0] FnOr   = 5'b00100;
  localparam logic [4:0] FnXor  = 5'b01000;
  localparam logic [4:0] FnNor  = 5'b01100;
  localparam logic [4:0] FnSll  = 5'b00010;
  localparam logic [4:0] FnSrl  = 5'b01010;
  localparam logic [4:0] FnSra  = 5'b01110;
  localparam logic [4:0] FnSlt  = 5'b10111;
  localparam logic [4:0] FnSltu = 5'b10011;

  localparam logic [N-1:0] LuiShift = N'(16);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e state_q, state_d;

  logic [N-1:0] alu_a_q, alu_a_d;
  logic [N-1:0] alu_b_q, alu_b_d;
  logic [4:0]   alu_fn_q, alu_fn_d;
  logic         beq_q, beq_d;
  logic         bne_q, bne_d;
  logic         ill_q, ill_d;
  logic [N-1:0] result_q, result_d;
  logic         taken_q, taken_d;
  logic         illegal_q, illegal_d;

  logic         accept;

  // Instruction fields
  logic [5:0]   opcode;
  logic [5:0]   funct;
  logic [4:0]   shamt;
  logic [N-1:0] imm_sext;
  logic [N-1:0] imm_zext;
  logic         unused_reg_fields;

  assign opcode   = instr[31:26];
  assign funct    = instr[5:0];
  assign shamt    = instr[10:6];
  assign imm_sext = {{(N-16){instr[15]}}, instr[15:0]};
  assign imm_zext = {{(N-16){1'b0}}, instr[15:0]};
  // Register indices arrive already resolved as rs_val/rt_val.
  assign unused_reg_fields = ^instr[25:11];

  // Decode
  logic [N-1:0] dec_a, dec_b;
  logic [4:0]   dec_fn;
  logic         dec_beq, dec_bne, dec_ill;

  always_comb begin
    dec_a   = '0;
    dec_b   = '0;
    dec_fn  = FnAdd;
    dec_beq = 1'b0;
    dec_bne = 1'b0;
    dec_ill = 1'b0;
    unique case (opcode)
      6'h00: begin
        dec_a = rs_val;
        dec_b = rt_val;
        unique case (funct)
          6'h20, 6'h21: dec_fn = FnAdd;
          6'h22, 6'h23: dec_fn = FnSub;
          6'h24:        dec_fn = FnAnd;
          6'h25:        dec_fn = FnOr;
          6'h26:        dec_fn = FnXor;
          6'h27:        dec_fn = FnNor;
          6'h2A:        dec_fn = FnSlt;
          6'h2B:        dec_fn = FnSltu;
          6'h00: begin
            dec_fn = FnSll;
            dec_a  = {{(N-5){1'b0}}, shamt};
          end
          6'h02: begin
            dec_fn = FnSrl;
            dec_a  = {{(N-5){1'b0}}, shamt};
          end
          6'h03: begin
            dec_fn = FnSra;
            dec_a  = {{(N-5){1'b0}}, shamt};
          end
          default: dec_ill = 1'b1;
        endcase
      end
      6'h08, 6'h09: begin
        dec_fn = FnAdd;
        dec_a  = rs_val;
        dec_b  = imm_sext;
      end
      6'h0A: begin
        dec_fn = FnSlt;
        dec_a  = rs_val;
        dec_b  = imm_sext;
      end
      6'h0B: begin
        dec_fn = FnSltu;
        dec_a  = rs_val;
        dec_b  = imm_sext;
      end
      6'h0C: begin
        dec_fn = FnAnd;
        dec_a  = rs_val;
        dec_b  = imm_zext;
      end
      6'h0D: begin
        dec_fn = FnOr;
        dec_a  = rs_val;
        dec_b  = imm_zext;
      end
      6'h0E: begin
        dec_fn = FnXor;
        dec_a  = rs_val;
        dec_b  = imm_zext;
      end
      // LUI is an SLL of the zero-extended immediate by 16.
      6'h0F: begin
        dec_fn = FnSll;
        dec_a  = LuiShift;
        dec_b  = imm_zext;
      end
      6'h04: begin
        dec_fn  = FnSub;
        dec_a   = rs_val;
        dec_b   = rt_val;
        dec_beq = 1'b1;
      end
      6'h05: begin
        dec_fn  = FnSub;
        dec_a   = rs_val;
        dec_b   = rt_val;
        dec_bne = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec_a   = '0;
      dec_b   = '0;
      dec_fn  = FnAdd;
      dec_beq = 1'b0;
      dec_bne = 1'b0;
    end
  end

  // Handshakes; in_ready is held low while reset is asserted.
  assign in_ready = rst_n & ((state_q == StIdle) | ((state_q == StDone) & out_ready));
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d   = state_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_fn_d  = alu_fn_q;
    beq_d     = beq_q;
    bne_d     = bne_q;
    ill_d     = ill_q;
    result_d  = result_q;
    taken_d   = taken_q;
    illegal_d = illegal_q;

    if (accept) begin
      alu_a_d  = dec_a;
      alu_b_d  = dec_b;
      alu_fn_d = dec_fn;
      beq_d    = dec_beq;
      bne_d    = dec_bne;
      ill_d    = dec_ill;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StExec;
      end
      StExec: begin
        result_d  = ill_q ? '0 : alu_R;
        taken_d   = (beq_q & alu_Z) | (bne_q & ~alu_Z);
        illegal_d = ill_q;
        state_d   = StDone;
      end
      StDone: begin
        if (out_ready) state_d = accept ? StExec : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_fn_q  <= 5'b00000;
      beq_q     <= 1'b0;
      bne_q     <= 1'b0;
      ill_q     <= 1'b0;
      result_q  <= '0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_fn_q  <= alu_fn_d;
      beq_q     <= beq_d;
      bne_q     <= bne_d;
      ill_q     <= ill_d;
      result_q  <= result_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
    end
  end

  assign alu_A       = alu_a_q;
  assign alu_B       = alu_b_q;
  assign alu_fn      = alu_fn_q;
  assign out_valid   = (state_q == StDone);
  assign out_result  = result_q;
  assign out_taken   = taken_q;
  assign out_illegal = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU model attached.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] alu_A;
  logic [31:0] alu_B;
  logic [4:0]  alu_fn;
  logic [31:0] alu_R;
  logic        alu_Z;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_taken;
  logic        out_illegal;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.N(32)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_fn     (alu_fn),
    .alu_R      (alu_R),
    .alu_Z      (alu_Z),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_taken  (out_taken),
    .out_illegal(out_illegal)
  );

  // Behavioural ALU: decodes ALUfn independently of the DUT.
  always_comb begin
    alu_R = '0;
    case (alu_fn)
      5'b00001: alu_R = alu_A + alu_B;
      5'b10001: alu_R = alu_A - alu_B;
      5'b00000: alu_R = alu_A & alu_B;
      5'b00100: alu_R = alu_A | alu_B;
      5'b01000: alu_R = alu_A ^ alu_B;
      5'b01100: alu_R = ~(alu_A | alu_B);
      5'b00010: alu_R = alu_B << alu_A[4:0];
      5'b01010: alu_R = alu_B >> alu_A[4:0];
      5'b01110: alu_R = $unsigned($signed(alu_B) >>> alu_A[4:0]);
      5'b10111: alu_R = {31'b0, $signed(alu_A) < $signed(alu_B)};
      5'b10011: alu_R = {31'b0, alu_A < alu_B};
      default:  alu_R = '0;
    endcase
    alu_Z = (alu_R == '0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one instruction in IDLE and let it be accepted.
  task automatic issue(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    instr    = ins;
    rs_val   = rs;
    rt_val   = rt;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: got 0x%08h expected 0x%08h", 0, 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    instr     = 32'h0000_0020;
    rs_val    = 32'd7;
    rt_val    = 32'd5;
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("post_rst_alu_fn", {27'b0, alu_fn}, 32'd0);
    @(negedge clk);

    // add 7+5
    issue(32'h0000_0020, 32'd7, 32'd5);
    check("add_fn", {27'b0, alu_fn}, 32'b00001);
    check("add_A", alu_A, 32'd7);
    check("add_valid_T1", {31'b0, out_valid}, 32'd0);
    step();
    check("add_valid", {31'b0, out_valid}, 32'd1);
    check("add_result", out_result, 32'd12);
    check("add_taken", {31'b0, out_taken}, 32'd0);
    check("add_illegal", {31'b0, out_illegal}, 32'd0);
    step();
    check("add_idle_ready", {31'b0, in_ready}, 32'd1);

    // sra by 4
    issue(32'h0000_0103, 32'd0, 32'h8000_0000);
    check("sra_A", alu_A, 32'd4);
    check("sra_fn", {27'b0, alu_fn}, 32'b01110);
    step();
    check("sra_result", out_result, 32'hF800_0000);
    step();

    // slti -3 < -1
    issue(32'h2800_FFFF, 32'hFFFF_FFFD, 32'd0);
    check("slti_B", alu_B, 32'hFFFF_FFFF);
    check("slti_fn", {27'b0, alu_fn}, 32'b10111);
    step();
    check("slti_result", out_result, 32'd1);
    step();

    // lui 0x1234
    issue(32'h3C00_1234, 32'd0, 32'd0);
    check("lui_A", alu_A, 32'd16);
    step();
    check("lui_result", out_result, 32'h1234_0000);
    step();

    // branches
    issue(32'h1000_0000, 32'd9, 32'd9);
    check("beq_fn", {27'b0, alu_fn}, 32'b10001);
    step();
    check("beq_eq_taken", {31'b0, out_taken}, 32'd1);
    step();
    issue(32'h1400_0000, 32'd9, 32'd9);
    step();
    check("bne_eq_taken", {31'b0, out_taken}, 32'd0);
    step();

    // bne 9,8 with downstream stall
    out_ready = 1'b0;
    issue(32'h1400_0000, 32'd9, 32'd8);
    step();
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", {31'b0, out_valid}, 32'd1);
      check("stall_taken", {31'b0, out_taken}, 32'd1);
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      step();
    end
    // Release and issue ori back-to-back
    out_ready = 1'b1;
    instr     = 32'h3400_000F;
    rs_val    = 32'h0000_00F0;
    rt_val    = 32'd0;
    in_valid  = 1'b1;
    #1;
    check("b2b_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check("b2b_gap_valid", {31'b0, out_valid}, 32'd0);
    step();
    check("b2b_valid", {31'b0, out_valid}, 32'd1);
    check("ori_result", out_result, 32'h0000_00FF);
    check("ori_taken", {31'b0, out_taken}, 32'd0);
    step();

    // illegal opcode 0x3F
    issue(32'hFC00_0000, 32'd3, 32'd4);
    check("ill_fn", {27'b0, alu_fn}, 32'b00001);
    check("ill_A", alu_A, 32'd0);
    step();
    check("ill_valid", {31'b0, out_valid}, 32'd1);
    check("ill_flag", {31'b0, out_illegal}, 32'd1);
    check("ill_result", out_result, 32'd0);
    step();

    // illegal R-type funct 0x3F
    issue(32'h0000_003F, 32'd3, 32'd4);
    step();
    check("ill_funct_flag", {31'b0, out_illegal}, 32'd1);
    step();

    // reset during EXEC
    issue(32'h0000_0020, 32'd1, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_exec_valid", {31'b0, out_valid}, 32'd0);
    check("rst_exec_fn", {27'b0, alu_fn}, 32'd0);
    check("rst_exec_result", out_result, 32'd0);
    check("rst_exec_illegal", {31'b0, out_illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst_exec_idle_ready", {31'b0, in_ready}, 32'd1);
    check("rst_exec_idle_valid", {31'b0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
